// File: rtl/bcd_freq_monitor.sv
// Packed-BCD frequency reading to binary (one digit per cycle, MSD first),
// followed by a low-frequency alarm with hysteresis thresholds and persistence.
module bcd_freq_monitor #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10,
  parameter int HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      thr_lo,
  input  logic [BIN_W-1:0]      thr_hi,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  out_valid,
  output logic                  err,
  output logic                  alarm
);

  localparam int ACC_W = BIN_W + 4;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(HOLD + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state, state_next;
  logic                ready_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_step;
  logic [IDX_W-1:0]    idx;
  logic [3:0]          digit;
  logic                bad, ovf;
  logic                step_bad, step_ovf;
  logic                take;
  logic [CNT_W-1:0]    low_cnt;
  logic [CNT_W-1:0]    cnt_inc;

  assign take      = in_valid && ready_q;
  assign in_ready  = ready_q;
  assign out_valid = (state == DONE);

  // Current digit is always the top nibble; bcd_q shifts left each CONV cycle.
  assign digit    = bcd_q[4*DIGITS-1 -: 4];
  assign acc_step = (acc << 3) + (acc << 1) + ACC_W'(digit);
  assign step_bad = bad | (digit > 4'd9);
  assign step_ovf = ovf | (|acc_step[ACC_W-1:BIN_W]);
  assign cnt_inc  = (low_cnt == CNT_W'(HOLD)) ? low_cnt : low_cnt + 1'b1;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = CONV;
      CONV:    if (idx == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  // ready_q stays low through reset and tracks "next state is IDLE" after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == IDLE);
    end
  end

  // NOTE: the conversion working registers carry no reset; each is loaded on
  // every accept before it is ever read.
  always_ff @(posedge clk) begin
    if (take) begin
      bcd_q <= bcd_in;
      acc   <= '0;
      idx   <= IDX_W'(DIGITS - 1);
      bad   <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == CONV) begin
      bcd_q <= bcd_q << 4;
      acc   <= acc_step;
      idx   <= idx - 1'b1;
      bad   <= step_bad;
      ovf   <= step_ovf;
    end
  end

  // Result is captured on the edge entering DONE; saturate on any fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_out <= '0;
      err     <= 1'b0;
    end else if (state == CONV && idx == '0) begin
      if (step_bad || step_ovf) begin
        err     <= 1'b1;
        bin_out <= '1;
      end else begin
        err     <= 1'b0;
        bin_out <= acc_step[BIN_W-1:0];
      end
    end
  end

  // Set path checked first, so overlapping thresholds still behave predictably.
  always_ff @(posedge clk) begin
    if (rst) begin
      low_cnt <= '0;
      alarm   <= 1'b0;
    end else if (state == DONE && !err) begin
      if (bin_out <= thr_lo) begin
        low_cnt <= cnt_inc;
        if (cnt_inc == CNT_W'(HOLD)) alarm <= 1'b1;
      end else if (bin_out >= thr_hi) begin
        low_cnt <= '0;
        alarm   <= 1'b0;
      end else begin
        low_cnt <= '0;
      end
    end
  end

endmodule
